// File: rtl/vend_sequencer.sv
// Vending machine sequencer: accumulates coin credit, releases the item at PRICE,
// then pays change or a cancel refund one coin at a time via a valid/ack handshake.
module vend_sequencer #(
  parameter int PRICE        = 5,
  parameter int FARTHING_VAL = 1,
  parameter int HALF_VAL     = 2,
  parameter int PENNY_VAL    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       cancel,
  input  logic       change_ack,
  output logic [3:0] credit,
  output logic       coin_accept,
  output logic       coin_reject,
  output logic       item_out,
  output logic       change_valid,
  output logic       change_coin,
  output logic       busy
);
  typedef enum logic [1:0] {S_COLLECT, S_VEND, S_PAYOUT} state_t;

  localparam logic [4:0] LP_PRICE = 5'(PRICE);
  localparam logic [4:0] LP_F     = 5'(FARTHING_VAL);
  localparam logic [4:0] LP_H     = 5'(HALF_VAL);
  localparam logic [4:0] LP_P     = 5'(PENNY_VAL);

  state_t     r_state;
  logic [3:0] r_credit;
  logic [3:0] r_payout;
  logic       r_accept;
  logic       r_reject;

  logic [4:0] w_val;
  logic [4:0] w_sum;
  logic       w_illegal;
  logic [3:0] w_pay_nxt;

  always_comb begin
    w_val = 5'd0;
    case (coin_type)
      2'b00:   w_val = LP_F;
      2'b01:   w_val = LP_H;
      2'b10:   w_val = LP_P;
      default: w_val = 5'd0;
    endcase
  end

  // sum kept 5 bits wide so an overflowing coin is seen before truncation
  assign w_sum     = {1'b0, r_credit} + w_val;
  assign w_illegal = (coin_type == 2'b11);
  assign w_pay_nxt = r_payout - ((r_payout >= 4'd2) ? 4'd2 : 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_COLLECT;
      r_credit <= 4'd0;
      r_payout <= 4'd0;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (cancel) begin
            r_reject <= coin_valid;
            if (r_credit != 4'd0) begin
              r_payout <= r_credit;
              r_credit <= 4'd0;
              r_state  <= S_PAYOUT;
            end
          end else if (coin_valid) begin
            if (w_illegal || (w_sum > 5'd15)) begin
              r_reject <= 1'b1;
            end else begin
              r_credit <= w_sum[3:0];
              r_accept <= 1'b1;
              if (w_sum >= LP_PRICE) r_state <= S_VEND;
            end
          end
        end
        S_VEND: begin
          r_reject <= coin_valid;
          r_payout <= r_credit - LP_PRICE[3:0];
          r_credit <= 4'd0;
          r_state  <= (r_credit == LP_PRICE[3:0]) ? S_COLLECT : S_PAYOUT;
        end
        S_PAYOUT: begin
          r_reject <= coin_valid;
          if (change_ack) begin
            r_payout <= w_pay_nxt;
            if (w_pay_nxt == 4'd0) r_state <= S_COLLECT;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  assign credit       = r_credit;
  assign coin_accept  = r_accept;
  assign coin_reject  = r_reject;
  assign item_out     = (r_state == S_VEND);
  assign change_valid = (r_state == S_PAYOUT);
  assign change_coin  = (r_state == S_PAYOUT) && (r_payout >= 4'd2);
  assign busy         = (r_state != S_COLLECT);
endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed vector table, async reset and overflow
// sequences, then random traffic against a credit/change-owed reference model.
module tb_vend_sequencer;
  localparam int PRICE = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid, cancel, change_ack;
  logic [1:0] coin_type;
  logic [3:0] credit;
  logic       coin_accept, coin_reject, item_out, change_valid, change_coin, busy;

  logic       b_cv;
  logic [1:0] b_ct;
  logic [3:0] b_credit;
  logic       b_acc, b_rej, b_item, b_chv, b_cc, b_busy;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  vend_sequencer #(.PRICE(PRICE)) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .change_ack(change_ack), .credit(credit),
    .coin_accept(coin_accept), .coin_reject(coin_reject), .item_out(item_out),
    .change_valid(change_valid), .change_coin(change_coin), .busy(busy));

  vend_sequencer #(.PRICE(15)) dut15 (
    .clk(clk), .reset(reset), .coin_valid(b_cv), .coin_type(b_ct),
    .cancel(1'b0), .change_ack(1'b0), .credit(b_credit),
    .coin_accept(b_acc), .coin_reject(b_rej), .item_out(b_item),
    .change_valid(b_chv), .change_coin(b_cc), .busy(b_busy));

  typedef struct {
    logic       cv;
    logic [1:0] ct;
    logic       cn;
    logic       ack;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  // {credit, accept, reject, item, change_valid, change_coin, busy}
  function automatic logic [9:0] outs();
    return {credit, coin_accept, coin_reject, item_out, change_valid, change_coin, busy};
  endfunction

  function automatic vec_t v(logic cv, logic [1:0] ct, logic cn, logic ack,
                             logic [3:0] cr, logic a, logic r, logic it,
                             logic chv, logic cc, logic b);
    vec_t t;
    t.cv = cv; t.ct = ct; t.cn = cn; t.ack = ack;
    t.exp = {cr, a, r, it, chv, cc, b};
    return t;
  endfunction

  task automatic chk(string nm, logic [9:0] act, logic [9:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic drive(logic cv, logic [1:0] ct, logic cn, logic ack);
    coin_valid = cv; coin_type = ct; cancel = cn; change_ack = ack;
    @(posedge clk); #1;
    coin_valid = 0; cancel = 0; change_ack = 0;
  endtask

  // Reference model: credit held, change still owed, and whether an item is due
  int m_credit, m_owed;
  bit m_vend, m_acc, m_rej;

  task automatic model_reset();
    m_credit = 0; m_owed = 0; m_vend = 0; m_acc = 0; m_rej = 0;
  endtask

  task automatic model_step(logic cv, logic [1:0] ct, logic cn, logic ack);
    int val;
    val = (ct == 0) ? 1 : (ct == 1) ? 2 : (ct == 2) ? 4 : 0;
    m_acc = 0; m_rej = 0;
    if (m_vend) begin
      m_rej = cv;
      m_owed = m_credit - PRICE;
      m_credit = 0;
      m_vend = 0;
    end else if (m_owed > 0) begin
      m_rej = cv;
      if (ack) m_owed = m_owed - ((m_owed >= 2) ? 2 : 1);
    end else if (cn) begin
      m_rej = cv;
      m_owed = m_credit;
      m_credit = 0;
    end else if (cv) begin
      if (ct == 3 || m_credit + val > 15) m_rej = 1;
      else begin
        m_credit += val;
        m_acc = 1;
        m_vend = (m_credit >= PRICE);
      end
    end
  endtask

  function automatic logic [9:0] model_outs();
    logic chv;
    chv = !m_vend && (m_owed > 0);
    return {4'(m_credit), m_acc, m_rej, m_vend, chv, chv && (m_owed >= 2), m_vend || chv};
  endfunction

  initial begin
    reset = 1; coin_valid = 0; coin_type = 0; cancel = 0; change_ack = 0;
    b_cv = 0; b_ct = 0;
    #12;
    chk("reset_state", outs(), 10'd0);
    reset = 0;
    @(posedge clk); #1;

    // farthing+half+half reaches price exactly
    tbl.push_back(v(1,0,0,0, 1,1,0,0,0,0,0));
    tbl.push_back(v(1,1,0,0, 3,1,0,0,0,0,0));
    tbl.push_back(v(1,1,0,0, 5,1,0,1,0,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0,0,0));
    // two pennies: 3 owed, offer held without ack
    tbl.push_back(v(1,2,0,0, 4,1,0,0,0,0,0));
    tbl.push_back(v(1,2,0,0, 8,1,0,1,0,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,1,1,1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,1,1,1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,1,1,1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,1,1,1));
    tbl.push_back(v(0,0,0,1, 0,0,0,0,1,0,1));
    tbl.push_back(v(0,0,0,1, 0,0,0,0,0,0,0));
    // cancel with a coin in the same cycle
    tbl.push_back(v(1,1,0,0, 2,1,0,0,0,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,1,0,1,1,1));
    tbl.push_back(v(0,0,0,1, 0,0,0,0,0,0,0));
    // coins and cancel during payout
    tbl.push_back(v(1,2,0,0, 4,1,0,0,0,0,0));
    tbl.push_back(v(1,2,0,0, 8,1,0,1,0,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,1,1,1));
    tbl.push_back(v(1,1,0,0, 0,0,1,0,1,1,1));
    tbl.push_back(v(1,0,1,1, 0,0,1,0,1,0,1));
    tbl.push_back(v(0,0,0,1, 0,0,0,0,0,0,0));
    // illegal coin, stray ack, plain cancel, cancel at zero credit
    tbl.push_back(v(1,1,0,0, 2,1,0,0,0,0,0));
    tbl.push_back(v(1,3,0,0, 2,0,1,0,0,0,0));
    tbl.push_back(v(0,0,0,1, 2,0,0,0,0,0,0));
    tbl.push_back(v(0,0,1,0, 0,0,0,0,1,1,1));
    tbl.push_back(v(0,0,0,1, 0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,1,0, 0,0,0,0,0,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].cv, tbl[i].ct, tbl[i].cn, tbl[i].ack);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // async reset in the middle of a payout
    drive(1,2,0,0); drive(1,2,0,0); drive(0,0,0,0);
    chk("pre_reset_payout", outs(), {4'd0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1});
    #3 reset = 1;
    #1 chk("async_reset", outs(), 10'd0);
    #2 reset = 0;
    drive(1,1,0,0);
    chk("post_reset_collect", outs(), {4'd2,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0});
    drive(0,0,1,0); drive(0,0,0,1);
    chk("post_reset_refund", outs(), 10'd0);

    // PRICE=15 instance: 14 plus a penny must not wrap
    for (int i = 0; i < 4; i++) begin
      b_cv = 1; b_ct = (i == 3) ? 2'b01 : 2'b10;
      @(posedge clk); #1;
    end
    chk("p15_credit14", {b_credit, b_acc, b_rej}, {4'd14, 1'b1, 1'b0});
    b_ct = 2'b10;
    @(posedge clk); #1;
    b_cv = 0;
    chk("p15_overflow", {b_credit, b_acc, b_rej, b_item}, {4'd14, 1'b0, 1'b1, 1'b0});

    // random traffic against the model
    reset = 1; #2 reset = 0;
    model_reset();
    for (int i = 0; i < 600; i++) begin
      logic cv, cn, ack;
      logic [1:0] ct;
      cv  = ($urandom_range(0, 1) == 1);
      ct  = 2'($urandom_range(0, 3));
      cn  = ($urandom_range(0, 9) == 0);
      ack = ($urandom_range(0, 2) != 0);
      model_step(cv, ct, cn, ack);
      drive(cv, ct, cn, ack);
      chk($sformatf("rand%0d", i), outs(), model_outs());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Sequencing controller for the vending machine.
- Accumulates inserted coins into a 4-bit credit register and decides when an item is released.
- Pays out change or refunds one coin at a time through a handshake with the coin dispenser.
- Sits between the coin acceptor front end and the item/change actuators.
- Replaces the purely combinational credit-to-output decode with a clocked flow that supports cancel and refund.

Parameters:
PRICE, 5, item price in farthings; legal range 1..15
FARTHING_VAL, 1, credit units added by a farthing
HALF_VAL, 2, credit units added by a half-penny
PENNY_VAL, 4, credit units added by a penny

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high reset
coin_valid  in  1  one-cycle strobe: a coin was inserted this cycle
coin_type  in  2  00 farthing, 01 half-penny, 10 penny, 11 illegal
cancel  in  1  level or pulse: request refund of current credit
change_ack  in  1  dispenser accepted the offered change coin
credit  out  4  current accumulated credit in farthings
coin_accept  out  1  one-cycle pulse: coin was added to credit
coin_reject  out  1  one-cycle pulse: coin returned via the reject chute
item_out  out  1  one-cycle pulse: release one item
change_valid  out  1  a change coin is being offered
change_coin  out  1  0 farthing, 1 half-penny; valid while change_valid is high
busy  out  1  high in VEND and PAYOUT states

Behaviour:
- Reset (asynchronous, active-high):
  - state=COLLECT, credit=0, payout=0.
  - All outputs 0 immediately, independent of clk.
  - Reset mid-payout abandons the remaining change; no recovery.
- Three states: COLLECT, VEND, PAYOUT. A 4-bit internal payout register holds the change still owed.
- COLLECT, priority order in a single cycle:
  - cancel: if credit>0, payout<=credit, credit<=0, go to PAYOUT; if credit==0, no action. A coin strobed in the same cycle is rejected (coin_reject=1).
  - coin_valid with illegal type: coin_reject=1, credit unchanged.
  - coin_valid, legal, credit+value<=15: credit<=credit+value, coin_accept=1. If the new credit>=PRICE, go to VEND.
  - coin_valid, legal, credit+value>15: coin_reject=1, credit unchanged. Credit never wraps.
- VEND (exactly one cycle):
  - item_out=1, busy=1.
  - payout<=credit-PRICE, credit<=0.
  - If credit-PRICE==0, go to COLLECT; otherwise go to PAYOUT.
- PAYOUT:
  - busy=1, change_valid=1.
  - change_coin=1 when payout>=2, else 0 (greedy selection).
  - change_valid and change_coin hold stable until change_ack is sampled high.
  - On ack: payout decrements by 2 or 1. If the result is 0, change_valid deasserts the next cycle and state returns to COLLECT.
  - change_ack while change_valid=0 is ignored.
- During VEND and PAYOUT:
  - Any coin_valid gives coin_reject=1.
  - cancel is ignored.
- Output timing:
  - coin_accept and coin_reject are registered pulses, one cycle after the coin strobe.
  - item_out and change outputs are Moore outputs of the state register.
- Latency: the coin edge that reaches PRICE leads to item_out in the next cycle. First change_valid follows the cycle after item_out.
- Credit width rule: all adds are evaluated 5 bits wide before the overflow comparison.

Test Plan:
- Reset asserted mid-PAYOUT, async (no clk edge) -> change_valid, busy, credit all 0 at once. After release, state is COLLECT.
- Insert farthing, half, half (1+2+2=5) -> credit 1,3,5, then item_out pulse one cycle. No change_valid; credit=0; back in COLLECT.
- Insert penny, penny (8) -> item_out, then change payout 3:
  - first offer is a half-penny (change_coin=1); hold change_ack low 3 cycles and check the offer stays stable;
  - ack, then a farthing offer (change_coin=0), ack -> idle.
- Insert half (credit=2), then cancel together with coin_valid -> coin_reject=1, payout of one half-penny, credit=0.
- Insert penny, penny, then a third coin during PAYOUT -> coin_reject=1 and payout unaffected. Separately, with PRICE=15: credit=14 plus a penny -> coin_reject, credit stays 14.
- Illegal coin_type=11 in COLLECT -> coin_reject=1, credit unchanged. change_ack pulsed in COLLECT -> no effect.
